// File: rtl/fetch_pkg.sv
// Fetch-side shared types: FSM states, exception codes (also used by the FIFO and decode)
// and the fetch-block geometry.
package fetch_pkg;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} fetch_state_t;

    localparam logic [2:0]  EXP_NONE    = 3'd0;
    localparam logic [2:0]  EXP_ADEL    = 3'd1;
    localparam int unsigned FETCH_BYTES = 8;

    function automatic logic [31:0] fetch_align(input logic [31:0] pc);
        return {pc[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: redirect/back-pressure inputs, I-cache port and FIFO write port.
// master = fetch unit, slave = I-cache + FIFO + redirect source.
interface instruction_fetch_unit_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fifo_full;

    logic        inst_req_valid;
    logic [31:0] inst_req_addr;
    logic        inst_req_ready;
    logic        inst_resp_valid;
    logic [63:0] inst_resp_data;

    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_data1;
    logic [31:0] write_address1;
    logic [31:0] write_data2;
    logic [31:0] write_address2;
    logic [2:0]  write_inst_exp1;

    modport master (
        input  redirect_valid, redirect_pc, fifo_full,
        input  inst_req_ready, inst_resp_valid, inst_resp_data,
        output inst_req_valid, inst_req_addr,
        output write_en1, write_en2, write_data1, write_address1,
        output write_data2, write_address2, write_inst_exp1
    );

    modport slave (
        output redirect_valid, redirect_pc, fifo_full,
        output inst_req_ready, inst_resp_valid, inst_resp_data,
        input  inst_req_valid, inst_req_addr,
        input  write_en1, write_en2, write_data1, write_address1,
        input  write_data2, write_address2, write_inst_exp1
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC register: redirect wins, otherwise advance past the slots just pushed.
// A request starting at word 1 of a block only delivers one instruction, hence the +4 step.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        resp_load_i,
    input  logic [31:0] req_pc_i,
    output logic [31:0] pc_o,
    output logic        pc_misaligned_o
);

    logic [31:0] pc_q, pc_d, step;

    always_comb begin
        step = req_pc_i[2] ? 32'd4 : 32'(FETCH_BYTES);
        pc_d = pc_q;
        if (redirect_valid_i)
            pc_d = redirect_pc_i;
        else if (resp_load_i)
            pc_d = req_pc_i + step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_o            = pc_q;
    assign pc_misaligned_o = (pc_q[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues 8-byte aligned I-cache fetches and pushes 1-2 entries per
// response into the instruction FIFO. Optional perf counters under `FETCH_PERF_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0]               perf_fetched,
    output logic [63:0]               perf_stall
`endif
);

    fetch_state_t state_q;
    logic         req_vld_q, drop_pend_q, sup_q;
    logic [31:0]  req_pc_q;
    logic         we1_q, we2_q;
    logic [31:0]  d1_q, a1_q, d2_q, a2_q;
    logic [2:0]   exp_q;

    logic [31:0]  pc;
    logic         pc_mis, hs, resp_load, start_req, take_exc;

    assign hs        = req_vld_q && bus.inst_req_ready;
    assign resp_load = (state_q == S_WAIT) && bus.inst_resp_valid && !bus.redirect_valid;
    assign start_req = (state_q == S_REQ) && !req_vld_q && !bus.redirect_valid &&
                       !bus.fifo_full && !pc_mis;
    // The cycle after a redirect must not push, so the address error waits one cycle.
    assign take_exc  = (state_q == S_REQ) && !req_vld_q && !bus.redirect_valid &&
                       !sup_q && pc_mis;

    fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid_i(bus.redirect_valid),
        .redirect_pc_i   (bus.redirect_pc),
        .resp_load_i     (resp_load),
        .req_pc_i        (req_pc_q),
        .pc_o            (pc),
        .pc_misaligned_o (pc_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            req_vld_q   <= 1'b0;
            drop_pend_q <= 1'b0;
            sup_q       <= 1'b0;
            req_pc_q    <= '0;
            we1_q       <= 1'b0;
            we2_q       <= 1'b0;
            d1_q        <= '0;
            a1_q        <= '0;
            d2_q        <= '0;
            a2_q        <= '0;
            exp_q       <= EXP_NONE;
        end else begin
            we1_q <= 1'b0;
            we2_q <= 1'b0;
            sup_q <= bus.redirect_valid;
            case (state_q)
                S_REQ: begin
                    if (req_vld_q) begin
                        // A launched request must complete; remember to drop its data.
                        if (bus.redirect_valid)
                            drop_pend_q <= 1'b1;
                        if (hs) begin
                            req_vld_q   <= 1'b0;
                            drop_pend_q <= 1'b0;
                            state_q     <= (drop_pend_q || bus.redirect_valid) ? S_DROP : S_WAIT;
                        end
                    end else if (start_req) begin
                        req_vld_q <= 1'b1;
                        req_pc_q  <= pc;
                    end else if (take_exc) begin
                        we1_q   <= 1'b1;
                        d1_q    <= '0;
                        a1_q    <= pc;
                        exp_q   <= EXP_ADEL;
                        state_q <= S_HALT;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect_valid) begin
                        state_q <= bus.inst_resp_valid ? S_REQ : S_DROP;
                    end else if (bus.inst_resp_valid) begin
                        state_q <= S_REQ;
                        we1_q   <= 1'b1;
                        we2_q   <= !req_pc_q[2];
                        d1_q    <= req_pc_q[2] ? bus.inst_resp_data[63:32] : bus.inst_resp_data[31:0];
                        a1_q    <= req_pc_q;
                        d2_q    <= bus.inst_resp_data[63:32];
                        a2_q    <= req_pc_q + 32'd4;
                        exp_q   <= EXP_NONE;
                    end
                end
                S_DROP: begin
                    if (bus.inst_resp_valid)
                        state_q <= S_REQ;
                end
                S_HALT: begin
                    if (bus.redirect_valid)
                        state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign bus.inst_req_valid  = req_vld_q;
    assign bus.inst_req_addr   = fetch_align(req_pc_q);
    assign bus.write_en1       = we1_q;
    assign bus.write_en2       = we2_q;
    assign bus.write_data1     = d1_q;
    assign bus.write_address1  = a1_q;
    assign bus.write_data2     = d2_q;
    assign bus.write_address2  = a2_q;
    assign bus.write_inst_exp1 = exp_q;

`ifdef FETCH_PERF_EN
    logic [63:0] fetched_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_q + 64'(we1_q && (exp_q == EXP_NONE)) + 64'(we2_q);
            if ((state_q == S_REQ) && bus.fifo_full && !req_vld_q)
                stall_q <= stall_q + 64'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: request addresses checked inline, FIFO
// pushes checked against a scoreboard filled when each response is driven.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] d1, a1, d2, a2;
        logic [2:0]  exp;
        logic        two;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    wr_t  sb[$];

    instruction_fetch_unit_if bus();
`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetched, perf_stall;
`endif

    instruction_fetch_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp_v);
        end
    endtask

    // FIFO write-port monitor
    always @(negedge clk) begin
        if (rst_n && bus.write_en2 && !bus.write_en1)
            chk("we2_alone", 1, 0);
        if (rst_n && bus.write_en1) begin
            if (sb.size() == 0) begin
                chk("unexp_wr", bus.write_address1, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_data1", bus.write_data1, e.d1);
                chk("wr_addr1", bus.write_address1, e.a1);
                chk("wr_exp", bus.write_inst_exp1, e.exp);
                chk("wr_en2", bus.write_en2, e.two);
                if (e.two) begin
                    chk("wr_data2", bus.write_data2, e.d2);
                    chk("wr_addr2", bus.write_address2, e.a2);
                end
            end
        end
    end

    task automatic wait_vld();
        int n = 0;
        while (!bus.inst_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_valid", bus.inst_req_valid, 1);
    endtask

    // One fetch at pc: check the request address, push expected entries, respond after lat cycles.
    task automatic fetch_one(input logic [31:0] pc, input logic [63:0] d, input int lat);
        wr_t e;
        wait_vld();
        chk("req_addr", bus.inst_req_addr, {pc[31:3], 3'b000});
        e.a1  = pc;
        e.exp = EXP_NONE;
        if (pc[2]) begin
            e.d1 = d[63:32]; e.two = 1'b0; e.d2 = '0; e.a2 = '0;
        end else begin
            e.d1 = d[31:0]; e.two = 1'b1; e.d2 = d[63:32]; e.a2 = pc + 32'd4;
        end
        sb.push_back(e);
        @(posedge clk);
        repeat (lat) @(negedge clk);
        bus.inst_resp_valid = 1'b1;
        bus.inst_resp_data  = d;
        @(negedge clk);
        bus.inst_resp_valid = 1'b0;
    endtask

    // Redirect while idle in S_REQ (full holds off a request for that cycle).
    task automatic redirect_idle(input logic [31:0] pc);
        bus.fifo_full      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.fifo_full      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        wr_t e;
        rst_n               = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.fifo_full       = 1'b0;
        bus.inst_req_ready  = 1'b1;
        bus.inst_resp_valid = 1'b0;
        bus.inst_resp_data  = '0;
        #3;
        chk("rst_vld", bus.inst_req_valid, 0);
        chk("rst_addr", bus.inst_req_addr, 0);
        chk("rst_we1", bus.write_en1, 0);
        chk("rst_we2", bus.write_en2, 0);
        chk("rst_d1", bus.write_data1, 0);
        chk("rst_a1", bus.write_address1, 0);
        chk("rst_d2", bus.write_data2, 0);
        chk("rst_a2", bus.write_address2, 0);
        chk("rst_exp", bus.write_inst_exp1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fetch_one(32'hBFC0_0000, 64'h2222_2222_1111_1111, 2);
        fetch_one(32'hBFC0_0008, 64'h4444_4444_3333_3333, 1);

        // back-pressure holds off the next request
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_novld", bus.inst_req_valid, 0);
        end
        bus.fifo_full = 1'b0;
        @(negedge clk);
        chk("vld_after_full", bus.inst_req_valid, 1);
`ifdef FETCH_PERF_EN
        chk("perf_stall", perf_stall, 5);
`endif
        fetch_one(32'hBFC0_0010, 64'h6666_6666_5555_5555, 3);

        // odd-word redirect gives a single slot
        redirect_idle(32'h8000_0004);
        fetch_one(32'h8000_0004, 64'hAAAA_AAAA_BBBB_BBBB, 2);
        fetch_one(32'h8000_0008, 64'h1234_5678_9ABC_DEF0, 1);

        // redirect during S_WAIT, stale response dropped
        wait_vld();
        chk("req_addr_w", bus.inst_req_addr, 32'h8000_0010);
        @(posedge clk);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h9000_0000;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drop_novld", bus.inst_req_valid, 0);
        end
        bus.inst_resp_valid = 1'b1;
        bus.inst_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        bus.inst_resp_valid = 1'b0;
        fetch_one(32'h9000_0000, 64'h0BAD_F00D_CAFE_BABE, 2);

        // misaligned pc: address error entry, then halt until redirect
        e.d1 = '0; e.a1 = 32'h8000_0002; e.d2 = '0; e.a2 = '0; e.exp = EXP_ADEL; e.two = 1'b0;
        sb.push_back(e);
        redirect_idle(32'h8000_0002);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("halt_novld", bus.inst_req_valid, 0);
        end
        chk("exc_pushed", sb.size(), 0);
        redirect_idle(32'h8000_0000);
        fetch_one(32'h8000_0000, 64'h7777_7777_8888_8888, 1);

        // request stalled on ready while redirected: address stable, response dropped
        bus.inst_req_ready = 1'b0;
        @(negedge clk);
        chk("stall_vld", bus.inst_req_valid, 1);
        chk("stall_addr", bus.inst_req_addr, 32'h8000_0008);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hA000_0000;
        bus.fifo_full      = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("hold_vld", bus.inst_req_valid, 1);
            chk("hold_addr", bus.inst_req_addr, 32'h8000_0008);
            @(negedge clk);
        end
        bus.fifo_full      = 1'b0;
        bus.inst_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.inst_resp_valid = 1'b1;
        bus.inst_resp_data  = 64'h5A5A_5A5A_A5A5_A5A5;
        @(negedge clk);
        bus.inst_resp_valid = 1'b0;
        fetch_one(32'hA000_0000, 64'h0101_0101_0202_0202, 1);

        // PC wrap at the top of the address space
        redirect_idle(32'hFFFF_FFF8);
        fetch_one(32'hFFFF_FFF8, 64'h3030_3030_4040_4040, 1);
        fetch_one(32'h0000_0000, 64'h5050_5050_6060_6060, 1);
        redirect_idle(32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 64'h7070_7070_8080_8080, 2);
        fetch_one(32'h0000_0000, 64'h9090_9090_A0A0_A0A0, 1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer side of the dual-issue instruction FIFO: generates the PC and issues aligned 64-bit fetches to the I-cache.
- Pushes one or two {instruction, address, exception} entries per response into the FIFO write port.
- Honours FIFO full back-pressure and branch/exception redirects, and discards stale responses after a redirect.
- Sits between the I-cache port and the instruction FIFO.

Parameters:
RESET_PC, 32'hBFC0_0000, PC loaded on reset.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
redirect_valid  input  1  flush/redirect request (branch resolve or exception).
redirect_pc  input  32  new fetch PC.
fifo_full  input  1  FIFO full flag (count >= 14).
inst_req_valid  output  1  fetch request valid.
inst_req_addr  output  32  fetch address, 8-byte aligned ({pc[31:3],3'b0}).
inst_req_ready  input  1  I-cache accepts the request.
inst_resp_valid  input  1  response data valid.
inst_resp_data  input  64  [31:0] = word at addr, [63:32] = word at addr+4.
write_en1  output  1  push slot 1.
write_en2  output  1  push slot 2 (only asserted together with write_en1).
write_data1  output  32  slot-1 instruction.
write_address1  output  32  slot-1 PC.
write_data2  output  32  slot-2 instruction.
write_address2  output  32  slot-2 PC.
write_inst_exp1  output  3  exception code applied to both slots.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_REQ.
  - All outputs 0: inst_req_valid=0, write_en*=0, data/address/exp=0.
- FSM states: S_REQ, S_WAIT, S_DROP, S_HALT.
- S_REQ:
  - Requires pc[1:0]==0. If pc[1:0]!=0, take the exception path below.
  - inst_req_valid=1 when !fifo_full. inst_req_addr is captured in req_pc_q on the cycle valid first rises.
  - Once valid is asserted, valid and addr stay stable until ready, independent of fifo_full and redirect.
  - Handshake (valid && ready) -> S_WAIT.
- S_WAIT, on inst_resp_valid, go to S_REQ and register the write outputs (they appear the next cycle, 1-cycle latency):
  - req_pc_q[2]==0: write_en1=write_en2=1; data1=resp[31:0], addr1=req_pc_q; data2=resp[63:32], addr2=req_pc_q+4; pc<=req_pc_q+8.
  - req_pc_q[2]==1: write_en1=1, write_en2=0; data1=resp[63:32], addr1=req_pc_q; pc<=req_pc_q+4.
  - write_inst_exp1=EXP_NONE.
- write_en* are single-cycle pulses. PC arithmetic is modulo 2^32; the wrap from 0xFFFF_FFF8 to 0 is legal.
- Exception path (S_REQ with pc[1:0]!=0):
  - No request is issued.
  - Next cycle: write_en1=1, write_en2=0, data1=0, addr1=pc, write_inst_exp1=EXP_ADEL.
  - Then enter S_HALT and stay there until a redirect.
- Redirect (highest priority, any state): pc<=redirect_pc. Write outputs are suppressed in that cycle and the next, even if inst_resp_valid coincides.
  - S_REQ, valid not yet asserted: restart from the new pc (stays in S_REQ).
  - S_REQ, valid asserted but not accepted: finish the handshake, then go to S_DROP.
  - S_WAIT without coincident resp: go to S_DROP.
  - S_WAIT with coincident resp: go to S_REQ; the response is discarded.
  - S_DROP: stay in S_DROP; pc is updated to the newest redirect_pc.
  - S_HALT: go to S_REQ.
- S_DROP: discard exactly one response, then go to S_REQ. At most one request is outstanding.
- Back-pressure: fifo_full only gates new requests. Full = count >= 14, so at least 2 free slots always remain for the single in-flight pair.
- Async reset mid-transaction: state is cleared immediately. The system resets the I-cache in the same reset, so no stale response follows.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: internal 64-bit counters, both cleared by reset:
  - fetched_inst_cnt, incremented by write_en1+write_en2 excluding exception entries.
  - full_stall_cnt, incremented each S_REQ cycle with fifo_full=1 and valid not yet asserted.
  - Both are exposed as output ports perf_fetched[63:0] and perf_stall[63:0].
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {S_REQ, S_WAIT, S_DROP, S_HALT}.
  - EXP_NONE=3'd0, EXP_ADEL=3'd1, shared with the FIFO and decode.
  - FETCH_BYTES=8.
- One sub-module, fetch_pc_gen: holds pc and computes the next pc from redirect, response and alignment. The FSM and output registers stay in the top.

Test Plan:
- Reset, ready=1, response 2 cycles after accept with data 64'h2222_2222_1111_1111 -> req_addr=0xBFC00000; write_en1=write_en2=1 with (0x11111111 @ 0xBFC00000, 0x22222222 @ 0xBFC00004); next req_addr=0xBFC00008.
- Redirect to 0x80000004, resp 64'hAAAA_AAAA_BBBB_BBBB -> req_addr=0x80000000; write_en1 only, data1=0xAAAAAAAA, addr1=0x80000004; next req_addr=0x80000008.
- fifo_full=1 for 5 cycles in S_REQ -> inst_req_valid stays 0; after full drops, valid rises the next cycle; perf_stall=5 with FETCH_PERF_EN.
- Redirect to 0x9000_0000 in S_WAIT, stale response arrives 3 cycles later -> no write_en; next request addr=0x90000000.
- Redirect to 0x80000002 -> no request; write_en1=1, addr1=0x80000002, exp=EXP_ADEL; FSM holds in S_HALT until redirect to 0x80000000 resumes fetching.
- req_valid held with ready=0 while redirect asserts -> addr stays stable until accept, response discarded, then fetch from redirect_pc.
